// File: rtl/riscv_defs.sv
// Shared RISC-V constants used by the ex and mem pipeline stages.
// Holds opcode values, funct3 access-width codes, mem-stage state encodings and load extension.
package riscv_defs;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Index of the final byte for a funct3[1:0] size code.
    function automatic logic [1:0] last_byte(input logic [1:0] size);
        case (size)
            2'b00:   last_byte = 2'd0;
            2'b01:   last_byte = 2'd1;
            default: last_byte = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                                input logic sext);
        case (size)
            2'b00:   load_extend = {{24{sext & raw[7]}}, raw[7:0]};
            2'b01:   load_extend = {{16{sext & raw[15]}}, raw[15:0]};
            default: load_extend = raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes non-memory results through and performs loads/stores
// as a sequence of single-byte accesses, stalling upstream until the last byte completes.
module mem_stage
    import riscv_defs::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        t_i,
    input  logic [2:0]        st_i,
    input  logic [4:0]        wa_i,
    input  logic              we_i,
    input  logic [31:0]       wn_i,
    input  logic [31:0]       sd_i,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rdy,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              stall_req,
    output logic [4:0]        wa_o,
    output logic              we_o,
    output logic [31:0]       wn_o
);

    logic [0:0]        state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       sd_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              store_q;
    logic [4:0]        wa_q;
    logic [31:0]       asm_q;

    logic        is_load, is_store, f3_ok, mem_op, last_hit;
    logic [31:0] asm_nxt;

    assign is_load  = (t_i == OP_LOAD);
    assign is_store = (t_i == OP_STORE);

    always_comb begin
        f3_ok = 1'b0;
        if (is_load) begin
            f3_ok = (st_i == F3_B) || (st_i == F3_H) || (st_i == F3_W) ||
                    (st_i == F3_BU) || (st_i == F3_HU);
        end else if (is_store) begin
            f3_ok = (st_i == F3_B) || (st_i == F3_H) || (st_i == F3_W);
        end
    end

    assign mem_op   = (is_load || is_store) && f3_ok;
    assign last_hit = (cnt_q == last_byte(size_q));

    // Load value including the byte arriving this cycle.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[{cnt_q, 3'b000} +: 8] = mem_rdata;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        stall_req = 1'b0;
        if (state_q == ST_ACCESS) begin
            mem_req   = 1'b1;
            mem_wr    = store_q;
            mem_addr  = base_q + ADDR_W'(cnt_q);
            mem_wdata = sd_q[{cnt_q, 3'b000} +: 8];
            stall_req = !(mem_rdy && last_hit);
        end else begin
            // Gated by rst so the stall drops the moment reset asserts.
            stall_req = mem_op && !rst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            base_q  <= '0;
            sd_q    <= 32'h0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            store_q <= 1'b0;
            wa_q    <= 5'd0;
            asm_q   <= 32'h0;
            wa_o    <= 5'd0;
            we_o    <= 1'b0;
            wn_o    <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_op) begin
                        base_q  <= ADDR_W'(wn_i);
                        sd_q    <= sd_i;
                        size_q  <= st_i[1:0];
                        sext_q  <= ~st_i[2];
                        store_q <= is_store;
                        wa_q    <= wa_i;
                        cnt_q   <= 2'd0;
                        asm_q   <= 32'h0;
                        we_o    <= 1'b0;
                        state_q <= ST_ACCESS;
                    end else if (is_load || is_store) begin
                        we_o <= 1'b0;
                    end else begin
                        wa_o <= wa_i;
                        we_o <= we_i;
                        wn_o <= wn_i;
                    end
                end
                ST_ACCESS: begin
                    we_o <= 1'b0;
                    if (mem_rdy) begin
                        if (!store_q) asm_q <= asm_nxt;
                        cnt_q <= cnt_q + 2'd1;
                        if (last_hit) begin
                            state_q <= ST_IDLE;
                            if (!store_q) begin
                                we_o <= 1'b1;
                                wa_o <= wa_q;
                                wn_o <= load_extend(asm_nxt, size_q, sext_q);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus byte-by-byte load/store
// sequences with wait states, address wrap and a mid-access reset.
module tb_mem_stage;
    import riscv_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  t_i;
    logic [2:0]  st_i;
    logic [4:0]  wa_i;
    logic        we_i;
    logic [31:0] wn_i;
    logic [31:0] sd_i;
    logic [7:0]  mem_rdata;
    logic        mem_rdy;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        stall_req;
    logic [4:0]  wa_o;
    logic        we_o;
    logic [31:0] wn_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .t_i       (t_i),
        .st_i      (st_i),
        .wa_i      (wa_i),
        .we_i      (we_i),
        .wn_i      (wn_i),
        .sd_i      (sd_i),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall_req (stall_req),
        .wa_o      (wa_o),
        .we_o      (we_o),
        .wn_o      (wn_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  t;
        logic [2:0]  st;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] wn;
        logic        chk_wb;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wn;
    } vec_t;

    vec_t vecs[6];

    task automatic idle_inputs();
        t_i = OP_IMM; st_i = 3'b000; wa_i = 5'd0; we_i = 1'b0;
        wn_i = 32'h0; sd_i = 32'h0; mem_rdy = 1'b0; mem_rdata = 8'h00;
    endtask

    // Runs one memory op starting just after a clock edge; ends just after the completing edge.
    task automatic mem_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input int nb,
                          input int wait_first, input logic [31:0] rbytes,
                          input logic exp_we, input logic [31:0] exp_wn, input logic [4:0] wa);
        logic is_st;
        logic rdy;
        is_st = (op == OP_STORE);
        t_i = op; st_i = f3; wn_i = addr; sd_i = sd; wa_i = wa; we_i = 1'b1; mem_rdy = 1'b0;
        #1;
        chk({name, " accept stall"}, 32'(stall_req), 32'd1);
        chk({name, " accept no req"}, 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        chk({name, " we after accept"}, 32'(we_o), 32'd0);
        // Upstream garbage during the access must be ignored.
        t_i = OP_LOAD; st_i = F3_W; wn_i = 32'hDEAD_BEEF; sd_i = 32'h5555_AAAA; wa_i = ~wa;
        for (int i = 0; i < nb; i++) begin
            for (int w = 0; w <= ((i == 0) ? wait_first : 0); w++) begin
                rdy = (w == ((i == 0) ? wait_first : 0));
                mem_rdy = rdy;
                mem_rdata = rbytes[8*i +: 8];
                #1;
                chk({name, " req"}, 32'(mem_req), 32'd1);
                chk({name, " wr"}, 32'(mem_wr), 32'(is_st));
                chk({name, " addr"}, mem_addr, addr + 32'(i));
                if (is_st) chk({name, " wdata"}, 32'(mem_wdata), 32'(sd[8*i +: 8]));
                chk({name, " stall"}, 32'(stall_req), 32'(!(rdy && (i == nb - 1))));
                @(posedge clk); #1;
                if (!(rdy && (i == nb - 1))) chk({name, " we mid"}, 32'(we_o), 32'd0);
            end
        end
        idle_inputs();
        #1;
        chk({name, " done we"}, 32'(we_o), 32'(exp_we));
        if (exp_we) begin
            chk({name, " done wn"}, wn_o, exp_wn);
            chk({name, " done wa"}, 32'(wa_o), 32'(wa));
        end
        chk({name, " idle req"}, 32'(mem_req), 32'd0);
        chk({name, " idle stall"}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        vecs[0] = '{OP_IMM,       3'b000, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b1, 5'd5,  32'h0000_1234};
        vecs[1] = '{7'b0110011,   3'b111, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
        vecs[2] = '{OP_IMM,       3'b010, 5'd7,  1'b0, 32'h0000_A5A5, 1'b1, 1'b0, 5'd7,  32'h0000_A5A5};
        vecs[3] = '{OP_LOAD,      3'b011, 5'd9,  1'b1, 32'h0000_0100, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[4] = '{OP_STORE,     3'b100, 5'd3,  1'b1, 32'h0000_0200, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[5] = '{OP_LOAD,      3'b111, 5'd4,  1'b1, 32'h0000_0300, 1'b0, 1'b0, 5'd0,  32'h0};

        idle_inputs();
        rst = 1'b1;
        #2;
        chk("reset req", 32'(mem_req), 32'd0);
        chk("reset wr", 32'(mem_wr), 32'd0);
        chk("reset addr", mem_addr, 32'd0);
        chk("reset wdata", 32'(mem_wdata), 32'd0);
        chk("reset stall", 32'(stall_req), 32'd0);
        chk("reset wa", 32'(wa_o), 32'd0);
        chk("reset we", 32'(we_o), 32'd0);
        chk("reset wn", wn_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Turn we_o on first so a no-op's we_o=0 is an observable change.
        for (int i = 0; i < 6; i++) begin
            t_i = vecs[i].t; st_i = vecs[i].st; wa_i = vecs[i].wa;
            we_i = vecs[i].we; wn_i = vecs[i].wn;
            #1;
            chk($sformatf("vec%0d stall", i), 32'(stall_req), 32'd0);
            chk($sformatf("vec%0d req", i), 32'(mem_req), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d we", i), 32'(we_o), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d req after", i), 32'(mem_req), 32'd0);
            if (vecs[i].chk_wb) begin
                chk($sformatf("vec%0d wa", i), 32'(wa_o), 32'(vecs[i].exp_wa));
                chk($sformatf("vec%0d wn", i), wn_o, vecs[i].exp_wn);
            end
            if (i == 2) begin
                t_i = OP_IMM; we_i = 1'b1; wa_i = 5'd1; wn_i = 32'h1;
                @(posedge clk); #1;
            end
        end
        idle_inputs();

        mem_op("LW",  OP_LOAD,  F3_W,  32'h0000_0100, 32'h0, 4, 0, 32'h1234_5678,
               1'b1, 32'h1234_5678, 5'd10);
        mem_op("LB",  OP_LOAD,  F3_B,  32'h0000_0003, 32'h0, 1, 0, 32'h0000_0080,
               1'b1, 32'hFFFF_FF80, 5'd11);
        mem_op("LBU", OP_LOAD,  F3_BU, 32'h0000_0003, 32'h0, 1, 0, 32'h0000_0080,
               1'b1, 32'h0000_0080, 5'd12);
        mem_op("LH",  OP_LOAD,  F3_H,  32'h0000_0011, 32'h0, 2, 1, 32'h0000_8001,
               1'b1, 32'hFFFF_8001, 5'd13);
        mem_op("LHU", OP_LOAD,  F3_HU, 32'h0000_0011, 32'h0, 2, 0, 32'h0000_8001,
               1'b1, 32'h0000_8001, 5'd14);
        mem_op("SH",  OP_STORE, F3_H,  32'hFFFF_FFFF, 32'h0000_BEEF, 2, 2, 32'h0,
               1'b0, 32'h0, 5'd15);
        mem_op("SW",  OP_STORE, F3_W,  32'h0000_0201, 32'hCAFE_F00D, 4, 0, 32'h0,
               1'b0, 32'h0, 5'd16);
        mem_op("SB",  OP_STORE, F3_B,  32'h0000_0300, 32'h0000_00A7, 1, 1, 32'h0,
               1'b0, 32'h0, 5'd17);

        // Reset while the second byte of a word load is outstanding.
        t_i = OP_LOAD; st_i = F3_W; wn_i = 32'h0000_0040; wa_i = 5'd20; we_i = 1'b1;
        @(posedge clk); #1;
        mem_rdy = 1'b1; mem_rdata = 8'h11;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        #1;
        chk("rst pre addr", mem_addr, 32'h0000_0041);
        rst = 1'b1;
        #1;
        chk("rst mid req", 32'(mem_req), 32'd0);
        chk("rst mid stall", 32'(stall_req), 32'd0);
        chk("rst mid we", 32'(we_o), 32'd0);
        idle_inputs();
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_op("LW after rst", OP_LOAD, F3_W, 32'h0000_0040, 32'h0, 4, 0, 32'hA1B2_C3D4,
               1'b1, 32'hA1B2_C3D4, 5'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
